// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: divided pixel clock, raster counters, registered sync/DE/RGB.
// Define VGA_TEST_PATTERN_EN to replace iColor with an internal 8-bar colour pattern.
module vga_timing_gen #(
    parameter int unsigned H_VISIBLE  = 640,
    parameter int unsigned H_FRONT    = 16,
    parameter int unsigned H_SYNC     = 96,
    parameter int unsigned H_BACK     = 48,
    parameter int unsigned V_VISIBLE  = 480,
    parameter int unsigned V_FRONT    = 10,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BACK     = 33,
    parameter int unsigned CLK_DIV    = 2,
    parameter bit          H_SYNC_POL = 1'b0,
    parameter bit          V_SYNC_POL = 1'b0,
    parameter int unsigned COORD_W    = 10
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic [2:0]         iColor,
    output logic [COORD_W-1:0] oColumn,
    output logic [COORD_W-1:0] oRow,
    output logic               oPixelTick,
    output logic               oFrameStart,
    output logic               oDisplayEnable,
    output logic               oHsync,
    output logic               oVsync,
    output logic               oRed,
    output logic               oGreen,
    output logic               oBlue
);

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0]   DIV_LAST     = DIV_W'(CLK_DIV - 1);
    localparam logic [COORD_W-1:0] H_LAST       = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] H_VIS        = COORD_W'(H_VISIBLE);
    localparam logic [COORD_W-1:0] H_SYNC_START = COORD_W'(H_VISIBLE + H_FRONT);
    localparam logic [COORD_W-1:0] H_SYNC_END   = COORD_W'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [COORD_W-1:0] V_LAST       = COORD_W'(V_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_VIS        = COORD_W'(V_VISIBLE);
    localparam logic [COORD_W-1:0] V_SYNC_START = COORD_W'(V_VISIBLE + V_FRONT);
    localparam logic [COORD_W-1:0] V_SYNC_END   = COORD_W'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [DIV_W-1:0]   div_q, div_d;
    logic [COORD_W-1:0] col_q, col_d;
    logic [COORD_W-1:0] row_q, row_d;
    logic               tick_q, frame_start_q;
    logic               de_q, de_d;
    logic               hsync_q, hsync_d;
    logic               vsync_q, vsync_d;
    logic [2:0]         rgb_q, rgb_d;

    logic               tick;
    logic               visible;
    logic               h_active;
    logic               v_active;
    logic               frame_wrap;
    logic [2:0]         pix_color;

`ifdef VGA_TEST_PATTERN_EN
    localparam int unsigned        BAR_W    = (H_VISIBLE / 8 > 0) ? H_VISIBLE / 8 : 1;
    localparam logic [COORD_W-1:0] BAR_LAST = COORD_W'(BAR_W - 1);

    logic [COORD_W-1:0] bar_cnt_q, bar_cnt_d;
    logic [2:0]         bar_q, bar_d;
    logic               unused_color;

    assign unused_color = ^iColor;

    // Bar index tracks the request column so it lines up with the coordinate being coloured.
    always_comb begin
        bar_cnt_d = bar_cnt_q;
        bar_d     = bar_q;
        if (tick) begin
            if (col_q == H_LAST) begin
                bar_cnt_d = '0;
                bar_d     = '0;
            end else if (bar_cnt_q == BAR_LAST) begin
                bar_cnt_d = '0;
                bar_d     = bar_q + 3'd1;
            end else begin
                bar_cnt_d = bar_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            bar_cnt_q <= '0;
            bar_q     <= '0;
        end else begin
            bar_cnt_q <= bar_cnt_d;
            bar_q     <= bar_d;
        end
    end

    assign pix_color = bar_q;
`else
    assign pix_color = iColor;
`endif

    always_comb begin
        tick       = (div_q == DIV_LAST);
        visible    = (col_q < H_VIS) && (row_q < V_VIS);
        h_active   = (col_q >= H_SYNC_START) && (col_q < H_SYNC_END);
        v_active   = (row_q >= V_SYNC_START) && (row_q < V_SYNC_END);
        frame_wrap = (col_q == H_LAST) && (row_q == V_LAST);

        div_d   = tick ? '0 : div_q + 1'b1;
        col_d   = col_q;
        row_d   = row_q;
        de_d    = de_q;
        hsync_d = hsync_q;
        vsync_d = vsync_q;
        rgb_d   = rgb_q;

        if (tick) begin
            if (col_q == H_LAST) begin
                col_d = '0;
                row_d = (row_q == V_LAST) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
            // Pipeline stage: outputs describe the pixel the counters are leaving.
            de_d    = visible;
            hsync_d = h_active ? H_SYNC_POL : ~H_SYNC_POL;
            vsync_d = v_active ? V_SYNC_POL : ~V_SYNC_POL;
            rgb_d   = visible ? pix_color : 3'b000;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            div_q         <= '0;
            col_q         <= '0;
            row_q         <= '0;
            tick_q        <= 1'b0;
            frame_start_q <= 1'b0;
            de_q          <= 1'b0;
            hsync_q       <= ~H_SYNC_POL;
            vsync_q       <= ~V_SYNC_POL;
            rgb_q         <= 3'b000;
        end else begin
            div_q         <= div_d;
            col_q         <= col_d;
            row_q         <= row_d;
            tick_q        <= tick;
            frame_start_q <= tick && frame_wrap;
            de_q          <= de_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            rgb_q         <= rgb_d;
        end
    end

    assign oColumn        = col_q;
    assign oRow           = row_q;
    assign oPixelTick     = tick_q;
    assign oFrameStart    = frame_start_q;
    assign oDisplayEnable = de_q;
    assign oHsync         = hsync_q;
    assign oVsync         = vsync_q;
    assign oRed           = rgb_q[2];
    assign oGreen         = rgb_q[1];
    assign oBlue          = rgb_q[0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three parameterisations checked against a closed-form raster model.
// Honours VGA_TEST_PATTERN_EN so the same bench covers the test-pattern build.
module tb_vga_timing_gen;

    typedef struct {
        int unsigned hv, hf, hs, hb, vv, vf, vs, vb, div;
        bit          hp, vp;
    } geom_t;

    typedef struct packed {
        logic [9:0] col;
        logic [9:0] row;
        logic       tick;
        logic       fs;
        logic       de;
        logic       hs;
        logic       vs;
        logic [2:0] rgb;
    } obs_t;

    int unsigned checks = 0;
    int unsigned errors = 0;

    logic       Clock = 1'b0;
    logic [2:0] rst   = 3'b111;
    logic [2:0] color [3];
    obs_t       obs   [3];

    always #5 Clock = ~Clock;

    // Instance 0: default 640x480 timing. Instance 1: tiny raster. Instance 2: mid-size, odd divider.
    logic [9:0] a_col, a_row;
    logic [3:0] b_col, b_row;
    logic [5:0] c_col, c_row;
    logic a_tick, a_fs, a_de, a_hs, a_vs, a_r, a_g, a_b;
    logic b_tick, b_fs, b_de, b_hs, b_vs, b_r, b_g, b_b;
    logic c_tick, c_fs, c_de, c_hs, c_vs, c_r, c_g, c_b;

    vga_timing_gen dut_a (
        .Clock(Clock), .Reset(rst[0]), .iColor(color[0]),
        .oColumn(a_col), .oRow(a_row), .oPixelTick(a_tick), .oFrameStart(a_fs),
        .oDisplayEnable(a_de), .oHsync(a_hs), .oVsync(a_vs),
        .oRed(a_r), .oGreen(a_g), .oBlue(a_b)
    );

    vga_timing_gen #(
        .H_VISIBLE(4), .H_FRONT(1), .H_SYNC(1), .H_BACK(1),
        .V_VISIBLE(2), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .CLK_DIV(1), .COORD_W(4)
    ) dut_b (
        .Clock(Clock), .Reset(rst[1]), .iColor(color[1]),
        .oColumn(b_col), .oRow(b_row), .oPixelTick(b_tick), .oFrameStart(b_fs),
        .oDisplayEnable(b_de), .oHsync(b_hs), .oVsync(b_vs),
        .oRed(b_r), .oGreen(b_g), .oBlue(b_b)
    );

    vga_timing_gen #(
        .H_VISIBLE(24), .H_FRONT(3), .H_SYNC(4), .H_BACK(5),
        .V_VISIBLE(5), .V_FRONT(2), .V_SYNC(3), .V_BACK(2),
        .CLK_DIV(3), .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b0), .COORD_W(6)
    ) dut_c (
        .Clock(Clock), .Reset(rst[2]), .iColor(color[2]),
        .oColumn(c_col), .oRow(c_row), .oPixelTick(c_tick), .oFrameStart(c_fs),
        .oDisplayEnable(c_de), .oHsync(c_hs), .oVsync(c_vs),
        .oRed(c_r), .oGreen(c_g), .oBlue(c_b)
    );

    assign obs[0] = {a_col, a_row, a_tick, a_fs, a_de, a_hs, a_vs, a_r, a_g, a_b};
    assign obs[1] = {6'd0, b_col, 6'd0, b_row, b_tick, b_fs, b_de, b_hs, b_vs, b_r, b_g, b_b};
    assign obs[2] = {4'd0, c_col, 4'd0, c_row, c_tick, c_fs, c_de, c_hs, c_vs, c_r, c_g, c_b};

    function automatic geom_t get_geom(input int d);
        geom_t g;
        case (d)
            0: g = '{hv: 640, hf: 16, hs: 96, hb: 48, vv: 480, vf: 10, vs: 2, vb: 33,
                     div: 2, hp: 1'b0, vp: 1'b0};
            1: g = '{hv: 4, hf: 1, hs: 1, hb: 1, vv: 2, vf: 1, vs: 1, vb: 1,
                     div: 1, hp: 1'b0, vp: 1'b0};
            default: g = '{hv: 24, hf: 3, hs: 4, hb: 5, vv: 5, vf: 2, vs: 3, vb: 2,
                           div: 3, hp: 1'b1, vp: 1'b0};
        endcase
        return g;
    endfunction

    function automatic logic [2:0] pix_color(input geom_t g, input int unsigned c,
                                             input logic [2:0] lat);
        int unsigned bw;
        bw = (g.hv / 8 > 0) ? g.hv / 8 : 1;
`ifdef VGA_TEST_PATTERN_EN
        return 3'((c / bw) % 8);
`else
        return (bw > 0) ? lat : 3'b000;
`endif
    endfunction

    function automatic obs_t reset_obs(input geom_t g);
        obs_t e;
        e     = '0;
        e.hs  = ~g.hp;
        e.vs  = ~g.vp;
        return e;
    endfunction

    // Expected outputs n clocks after the last reset edge (n >= 1); lat = iColor at the last tick.
    function automatic obs_t model(input geom_t g, input int unsigned n, input logic [2:0] lat);
        obs_t        e;
        int unsigned ht, vt, k, p, c, r;
        ht    = g.hv + g.hf + g.hs + g.hb;
        vt    = g.vv + g.vf + g.vs + g.vb;
        k     = n / g.div;
        e     = reset_obs(g);
        e.col = 10'(k % ht);
        e.row = 10'((k / ht) % vt);
        e.tick = (n % g.div == 0);
        e.fs   = e.tick && (k % (ht * vt) == 0);
        if (k > 0) begin
            p     = k - 1;
            c     = p % ht;
            r     = (p / ht) % vt;
            e.de  = (c < g.hv) && (r < g.vv);
            e.hs  = (c >= g.hv + g.hf && c < g.hv + g.hf + g.hs) ? g.hp : ~g.hp;
            e.vs  = (r >= g.vv + g.vf && r < g.vv + g.vf + g.vs) ? g.vp : ~g.vp;
            e.rgb = e.de ? pix_color(g, c, lat) : 3'b000;
        end
        return e;
    endfunction

    // Stimulus only: returns on the negedge at which Reset drops.
    task automatic apply_reset(input int d, input int unsigned hold);
        @(negedge Clock);
        rst[d] = 1'b1;
        repeat (hold) @(posedge Clock);
        @(negedge Clock);
        rst[d] = 1'b0;
    endtask

    task automatic test_reset();
        geom_t g;
        @(negedge Clock);
        rst = 3'b111;
        repeat (5) @(posedge Clock);
        #1;
        for (int d = 0; d < 3; d++) begin
            g = get_geom(d);
            checks++;
            if (obs[d] !== reset_obs(g)) begin
                errors++;
                $display("FAIL reset_values dut%0d actual=%h required=%h", d, obs[d], reset_obs(g));
            end
        end
        checks++;
        if ({a_hs, a_vs} !== 2'b11) begin
            errors++;
            $display("FAIL reset_sync_idle actual=%b required=11", {a_hs, a_vs});
        end
        @(negedge Clock);
        rst = 3'b000;
    endtask

    task automatic test_hline();
        geom_t       g = get_geom(0);
        obs_t        e;
        logic [2:0]  lat = 3'b000;
        int unsigned errs = 0, hs_low = 0, hs_first = 0, de_high = 0, rise0 = 0, rise1 = 0;
        logic        de_prev = 1'b0;
        apply_reset(0, 2);
        for (int unsigned n = 1; n <= 3300; n++) begin
            color[0] = 3'($urandom);
            @(posedge Clock);
            #1;
            if (n % g.div == 0) lat = color[0];
            e = model(g, n, lat);
            checks++;
            if (obs[0] !== e) begin
                errors++;
                errs++;
                $display("FAIL hline n=%0d actual=%h required=%h", n, obs[0], e);
                if (errs >= 5) break;
            end
            if (n <= 1600) begin
                if (!a_hs) begin
                    hs_low++;
                    if (hs_first == 0) hs_first = n;
                end
                if (a_de) de_high++;
            end
            if (a_de && !de_prev) begin
                if (rise0 == 0) rise0 = n;
                else if (rise1 == 0) rise1 = n;
            end
            de_prev = a_de;
            @(negedge Clock);
        end
        checks++;
        if (hs_low !== 192) begin
            errors++;
            $display("FAIL hsync_width actual=%0d required=192", hs_low);
        end
        checks++;
        if (hs_first !== 1314) begin
            errors++;
            $display("FAIL hsync_start_col656 actual=%0d required=1314", hs_first);
        end
        checks++;
        if (de_high !== 1280) begin
            errors++;
            $display("FAIL de_per_line actual=%0d required=1280", de_high);
        end
        checks++;
        if (rise1 - rise0 !== 1600) begin
            errors++;
            $display("FAIL line_period actual=%0d required=1600", rise1 - rise0);
        end
    endtask

    task automatic test_color();
        geom_t       g = get_geom(0);
        obs_t        e;
        logic [2:0]  lat = 3'b000;
        int unsigned errs = 0, blank_colour = 0, de_cycles = 0;
        apply_reset(0, 1);
        for (int unsigned n = 1; n <= 1700; n++) begin
`ifdef VGA_TEST_PATTERN_EN
            color[0] = 3'($urandom);
`else
            color[0] = 3'b101;
`endif
            @(posedge Clock);
            #1;
            if (n % g.div == 0) lat = color[0];
            e = model(g, n, lat);
            checks++;
            if (obs[0] !== e) begin
                errors++;
                errs++;
                $display("FAIL colour n=%0d actual=%h required=%h", n, obs[0], e);
                if (errs >= 5) break;
            end
            if (!a_de && {a_r, a_g, a_b} != 3'b000) blank_colour++;
            if (a_de) de_cycles++;
            @(negedge Clock);
        end
        checks++;
        if (blank_colour !== 0 || de_cycles == 0) begin
            errors++;
            $display("FAIL colour_blanking actual=%0d/%0d required=0/nonzero",
                     blank_colour, de_cycles);
        end
    endtask

    task automatic test_frame();
        geom_t       g = get_geom(2);
        obs_t        e;
        logic [2:0]  lat = 3'b000;
        int unsigned errs = 0, fs_cnt = 0, fs_last = 0, vs_low = 0, period, ht;
        logic        fs_prev = 1'b0;
        ht     = g.hv + g.hf + g.hs + g.hb;
        period = ht * (g.vv + g.vf + g.vs + g.vb) * g.div;
        apply_reset(2, 3);
        for (int unsigned n = 1; n <= 3 * period + 50; n++) begin
            color[2] = 3'($urandom);
            @(posedge Clock);
            #1;
            if (n % g.div == 0) lat = color[2];
            e = model(g, n, lat);
            checks++;
            if (obs[2] !== e) begin
                errors++;
                errs++;
                $display("FAIL frame n=%0d actual=%h required=%h", n, obs[2], e);
                if (errs >= 5) break;
            end
            if (n <= period && !c_vs) vs_low++;
            if (c_fs) begin
                checks++;
                if (fs_prev || n - fs_last !== period) begin
                    errors++;
                    $display("FAIL frame_start_spacing actual=%0d required=%0d",
                             n - fs_last, period);
                end
                fs_cnt++;
                fs_last = n;
            end
            fs_prev = c_fs;
            @(negedge Clock);
        end
        checks++;
        if (fs_cnt !== 3) begin
            errors++;
            $display("FAIL frame_start_count actual=%0d required=3", fs_cnt);
        end
        checks++;
        if (vs_low !== g.vs * ht * g.div) begin
            errors++;
            $display("FAIL vsync_width actual=%0d required=%0d", vs_low, g.vs * ht * g.div);
        end
    endtask

    task automatic test_small();
        geom_t       g = get_geom(1);
        obs_t        e;
        logic [2:0]  lat = 3'b000;
        int unsigned errs = 0, budget = 100;
        apply_reset(1, 1);
        for (int unsigned n = 1; n <= 80; n++) begin
            color[1] = 3'($urandom);
            @(posedge Clock);
            #1;
            lat = color[1];
            e   = model(g, n, lat);
            checks++;
            if (obs[1] !== e) begin
                errors++;
                errs++;
                $display("FAIL small n=%0d actual=%h required=%h", n, obs[1], e);
                if (errs >= 5) break;
            end
            @(negedge Clock);
        end
        while (!(b_col == 4'd3 && b_row == 4'd1) && budget > 0) begin
            @(negedge Clock);
            budget--;
        end
        checks++;
        if (budget == 0) begin
            errors++;
            $display("FAIL small_reach_3_1 actual=(%0d,%0d) required=(3,1)", b_col, b_row);
        end
        rst[1] = 1'b1;
        @(posedge Clock);
        #1;
        checks++;
        if (obs[1] !== reset_obs(g)) begin
            errors++;
            $display("FAIL small_mid_reset actual=%h required=%h", obs[1], reset_obs(g));
        end
        @(negedge Clock);
        rst[1] = 1'b0;
    endtask

    task automatic test_random_reset();
        geom_t       g;
        obs_t        e;
        logic [2:0]  lat;
        int          d;
        int unsigned errs, len;
        for (int it = 0; it < 6; it++) begin
            d    = $urandom_range(0, 2);
            g    = get_geom(d);
            len  = $urandom_range(10, 800);
            lat  = 3'b000;
            errs = 0;
            @(negedge Clock);
            rst[d] = 1'b1;
            @(posedge Clock);
            #1;
            checks++;
            if (obs[d] !== reset_obs(g)) begin
                errors++;
                $display("FAIL rand_reset_entry dut%0d actual=%h required=%h",
                         d, obs[d], reset_obs(g));
            end
            repeat ($urandom_range(0, 2)) @(posedge Clock);
            @(negedge Clock);
            rst[d] = 1'b0;
            for (int unsigned n = 1; n <= len; n++) begin
                color[d] = 3'($urandom);
                @(posedge Clock);
                #1;
                if (n % g.div == 0) lat = color[d];
                e = model(g, n, lat);
                checks++;
                if (obs[d] !== e) begin
                    errors++;
                    errs++;
                    $display("FAIL rand_run dut%0d n=%0d actual=%h required=%h", d, n, obs[d], e);
                    if (errs >= 5) break;
                end
                @(negedge Clock);
            end
        end
    endtask

    initial begin
        for (int d = 0; d < 3; d++) color[d] = 3'b000;
        test_reset();
        test_hline();
        test_color();
        test_frame();
        test_small();
        test_random_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
